core_control_fsm: RTL
=====================

Name: core_control_fsm

Overview:
Multi-cycle sequencer for the RV32I integer core: drives fetch, decode, execute, memory and writeback around the integer instruction decoder, ALU, register file and PC.
Consumes decoder control outputs (jump, branch, reg_w, data_r, data_w, alu_sel) and issues per-phase enables plus req/ack handshakes on the instruction and data buses.
Keeps a retired-instruction counter.

Parameters:
RESET_WAIT, 1, idle cycles after reset release before first fetch (min 1).
TIMEOUT_CYCLES, 255, bus wait limit used only with CONTROL_TIMEOUT_EN.

Ports:
clk  input  1  core clock; all state updates on rising edge
rst_n  input  1  synchronous, active-low reset
instr_ack  input  1  instruction bus ack; instruction valid this cycle
data_ack  input  1  data bus ack; load data valid / store accepted this cycle
dec_valid  input  1  decoder recognises the instruction (0 = illegal)
dec_jump  input  1  decoder jump
dec_branch  input  1  decoder branch
dec_reg_w  input  1  decoder register write
dec_data_r  input  1  decoder load
dec_data_w  input  1  decoder store
branch_taken  input  1  ALU branch condition, valid in EXEC
instr_req  output  1  instruction fetch request
ir_w  output  1  load instruction register
alu_en  output  1  ALU operands/result capture
data_req  output  1  data bus request
data_we  output  1  data bus write (valid with data_req)
rf_w  output  1  register file write enable
pc_w  output  1  PC update enable
pc_sel  output  1  0 = PC+4, 1 = jump/branch target
halted  output  1  core stopped on illegal instruction or bus timeout
instret  output  32  retired instruction count

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. All outputs Moore-decoded from state, except ir_w = FETCH && instr_ack and pc_sel.
- rst_n=0 at any edge: state IDLE, wait counter = RESET_WAIT, instret = 0, all outputs 0. Applies mid-transaction: an outstanding request is dropped with no completion.
- IDLE: decrement wait counter; when 0 -> FETCH. First instr_req appears RESET_WAIT+1 cycles after rst_n rises.
- FETCH: instr_req=1 held until instr_ack; on ack ir_w=1 for that cycle, -> DECODE. Ack in the first FETCH cycle is legal (one-cycle fetch).
- DECODE: one cycle, no outputs. dec_valid=0 -> HALT; else -> EXEC.
- EXEC: alu_en=1 for one cycle. If dec_data_r or dec_data_w -> MEM, else -> WB. Decoder inputs and branch_taken are sampled here and registered for WB.
- MEM: data_req=1, data_we=dec_data_w, held until data_ack -> WB. No request is withdrawn before ack.
- WB: rf_w = registered reg_w (loads write here); pc_w=1; pc_sel = jump || (branch && branch_taken); instret += 1 (wraps 0xFFFFFFFF -> 0); -> FETCH.
- HALT: terminal; halted=1; every other output 0; exit only via reset.
- Latency, zero-wait bus: ALU/branch/jump = 4 cycles (FETCH, DECODE, EXEC, WB); load/store = 5.
- Acks arriving outside their request state are ignored.
- data_req and instr_req are never high together.

Optional Feature:
CONTROL_TIMEOUT_EN: when defined, an 8-bit+ wait counter (sized for TIMEOUT_CYCLES) runs in FETCH and MEM. It clears on state entry. If it reaches TIMEOUT_CYCLES with no ack, the FSM goes to HALT.
When not defined: no counter; the FSM waits indefinitely in FETCH or MEM.

Test Plan:
- Reset, RESET_WAIT=1: release rst_n, ack immediately -> instr_req high on the 2nd edge after release; ir_w pulses with ack; halted=0, instret=0.
- ADD (reg_w=1, no mem), zero-wait -> rf_w and pc_w high in WB with pc_sel=0; instret increments by 1 every 4 cycles.
- Load (data_r=1), data_ack delayed 3 cycles -> data_req held 4 cycles with data_we=0; rf_w in the WB after ack; 8 cycles total.
- BEQ: branch_taken=1 -> pc_sel=1, rf_w=0. Repeat with branch_taken=0 -> pc_sel=0. Store -> data_we=1, rf_w=0.
- Illegal (dec_valid=0) -> HALT after DECODE, halted=1, no further instr_req. rst_n=0 while in MEM -> all outputs 0 next edge, instret=0.
- CONTROL_TIMEOUT_EN, TIMEOUT_CYCLES=4, instr_ack never -> halted=1 after 4 FETCH cycles. Without the macro: still in FETCH after 1000 cycles. Preload instret near wrap (force) -> 0xFFFFFFFF increments to 0.

Source files
------------

// File: rtl/core_control_fsm.sv
// core_control_fsm: multi-cycle RV32I sequencer (fetch/decode/exec/mem/wb) with retired-instruction counter.
// Optional CONTROL_TIMEOUT_EN: halts when FETCH or MEM waits TIMEOUT_CYCLES without an ack.
module core_control_fsm #(
    parameter int RESET_WAIT     = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_ack,
    input  logic        data_ack,
    input  logic        dec_valid,
    input  logic        dec_jump,
    input  logic        dec_branch,
    input  logic        dec_reg_w,
    input  logic        dec_data_r,
    input  logic        dec_data_w,
    input  logic        branch_taken,
    output logic        instr_req,
    output logic        ir_w,
    output logic        alu_en,
    output logic        data_req,
    output logic        data_we,
    output logic        rf_w,
    output logic        pc_w,
    output logic        pc_sel,
    output logic        halted,
    output logic [31:0] instret
);
    localparam int WW = $clog2(RESET_WAIT + 2);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    state_t          state, nxt;
    logic [WW-1:0]   wcnt;
    logic            r_reg_w, r_sel, r_data_w;
    logic            wb_rf, wb_sel, mem_we, tmo;

`ifdef CONTROL_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TW-1:0] tcnt;
    assign tmo = tcnt == TW'(TIMEOUT_CYCLES - 1);
    // bus wait counter: counts consecutive FETCH/MEM cycles, cleared on every state change
    always_ff @(posedge clk) begin
        if (!rst_n) tcnt <= '0;
        else tcnt <= (nxt == state && (state == FETCH || state == MEM)) ? tcnt + 1'b1 : '0;
    end
`else
    assign tmo = (TIMEOUT_CYCLES < 0);
`endif

    assign ir_w   = (state == FETCH) && instr_ack;
    assign wb_rf  = (state == EXEC) ? dec_reg_w : r_reg_w;
    assign wb_sel = (state == EXEC) ? (dec_jump | (dec_branch & branch_taken)) : r_sel;
    assign mem_we = (state == EXEC) ? dec_data_w : r_data_w;

    // next-state decode
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = (wcnt == '0) ? FETCH : IDLE;
            FETCH:   nxt = instr_ack ? DECODE : tmo ? HALT : FETCH;
            DECODE:  nxt = dec_valid ? EXEC : HALT;
            EXEC:    nxt = (dec_data_r | dec_data_w) ? MEM : WB;
            MEM:     nxt = data_ack ? WB : tmo ? HALT : MEM;
            WB:      nxt = FETCH;
            HALT:    nxt = HALT;
            default: nxt = IDLE;
        endcase
    end

    // state, captured decode, retire counter and outputs registered from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wcnt      <= WW'(RESET_WAIT);
            instret   <= '0;
            r_reg_w   <= 1'b0;
            r_sel     <= 1'b0;
            r_data_w  <= 1'b0;
            instr_req <= 1'b0;
            alu_en    <= 1'b0;
            data_req  <= 1'b0;
            data_we   <= 1'b0;
            rf_w      <= 1'b0;
            pc_w      <= 1'b0;
            pc_sel    <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && wcnt != '0) wcnt <= wcnt - 1'b1;
            if (state == EXEC) begin
                r_reg_w  <= dec_reg_w;
                r_sel    <= dec_jump | (dec_branch & branch_taken);
                r_data_w <= dec_data_w;
            end
            if (state == WB) instret <= instret + 32'd1;
            instr_req <= nxt == FETCH;
            alu_en    <= nxt == EXEC;
            data_req  <= nxt == MEM;
            data_we   <= nxt == MEM && mem_we;
            rf_w      <= nxt == WB && wb_rf;
            pc_w      <= nxt == WB;
            pc_sel    <= nxt == WB && wb_sel;
            halted    <= nxt == HALT;
        end
    end
endmodule
